// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Conditions the board push-buttons. Each raw active-low key pin is brought
//   into the clk domain through a two-flop synchroniser and then debounced on
//   its own: a new level is accepted only after it has been seen unchanged for
//   DB_CYCLES consecutive clock edges. The accepted level is presented on
//   key_out, and every accepted change produces a one-cycle press (1->0) or
//   release (0->1) pulse on the same edge.
//
//   Optional feature (macro KEY_LONG_PRESS_EN):
//     When defined, the port key_long is added. While a key stays pressed on
//     key_out, a per-key hold counter runs. After LONG_CYCLES cycles of holding,
//     key_long pulses once for that key, and it does not pulse again until the
//     key has been released. When the macro is undefined, neither the port nor
//     the hold counters exist.
//
// Parameters
//   N_KEYS       number of independent keys
//   DB_CYCLES    stable cycles needed before a new level is accepted (>= 2)
//   LONG_CYCLES  cycles a key must be held for a long-press pulse (>= 2)
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   key_in       raw key pins (asynchronous), 0 = pressed, 1 = released
//   key_out      debounced level, 0 = pressed, 1 = released
//   key_press    one-cycle pulse when key_out[i] goes 1->0
//   key_release  one-cycle pulse when key_out[i] goes 0->1
//   key_long     one-cycle long-press pulse (only with KEY_LONG_PRESS_EN)
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int N_KEYS      = 4,
  parameter int DB_CYCLES   = 1_000_000,
  parameter int LONG_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_out,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
`ifdef KEY_LONG_PRESS_EN
  ,
  output logic [N_KEYS-1:0] key_long
`endif
);

  // A counter of $clog2(DB_CYCLES) bits reaches DB_CYCLES-1 without wrapping.
  localparam int              DBW    = $clog2(DB_CYCLES);
  localparam logic [DBW-1:0]  DB_MAX = DBW'(DB_CYCLES - 1);
  localparam logic [DBW-1:0]  DB_ONE = DBW'(1);

  // Parameter sanity: a debounce or hold window shorter than 2 cycles would
  // give zero-width counters.
  if (DB_CYCLES < 2) begin : g_bad_db_cycles
    $error("key_debounce: DB_CYCLES must be >= 2");
  end
  if (LONG_CYCLES < 2) begin : g_bad_long_cycles
    $error("key_debounce: LONG_CYCLES must be >= 2");
  end

  // Synchroniser stages.
  logic [N_KEYS-1:0] sync1_q, sync1_d;
  logic [N_KEYS-1:0] sync2_q, sync2_d;

  // Debounce state and registered outputs.
  logic [N_KEYS-1:0] key_out_q, key_out_d;
  logic [N_KEYS-1:0] key_press_q, key_press_d;
  logic [N_KEYS-1:0] key_release_q, key_release_d;
  logic [DBW-1:0]    db_cnt_q [N_KEYS];
  logic [DBW-1:0]    db_cnt_d [N_KEYS];

  // ---------------------------------------------------------------------------
  // Stage 0/1: two-flop synchroniser. Only sync2 is used by the debouncer.
  // ---------------------------------------------------------------------------
  always_comb begin
    sync1_d = key_in;
    sync2_d = sync1_q;
  end

  // ---------------------------------------------------------------------------
  // Stage 2: per-key debounce counter and level/pulse update.
  // ---------------------------------------------------------------------------
  always_comb begin
    key_out_d     = key_out_q;
    key_press_d   = '0;
    key_release_d = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      // Any agreement between the synchronised input and the accepted level
      // restarts the window, which is what rejects glitches.
      db_cnt_d[i] = '0;
      if (sync2_q[i] != key_out_q[i]) begin
        if (db_cnt_q[i] == DB_MAX) begin
          // DB_CYCLES mismatching edges seen: accept the new level. The count
          // returns to zero because input and level now agree.
          key_out_d[i]     = sync2_q[i];
          key_press_d[i]   = ~sync2_q[i];
          key_release_d[i] =  sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= '1;
      sync2_q       <= '1;
      key_out_q     <= '1;
      key_press_q   <= '0;
      key_release_q <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      key_out_q     <= key_out_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      for (int i = 0; i < N_KEYS; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign key_out     = key_out_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;

`ifdef KEY_LONG_PRESS_EN
  localparam int              LPW    = $clog2(LONG_CYCLES);
  localparam logic [LPW-1:0]  LP_MAX = LPW'(LONG_CYCLES - 1);
  localparam logic [LPW-1:0]  LP_ONE = LPW'(1);

  logic [LPW-1:0]    lp_cnt_q [N_KEYS];
  logic [LPW-1:0]    lp_cnt_d [N_KEYS];
  // Set once the long pulse has fired for the current hold, so the saturated
  // counter does not keep re-triggering it.
  logic [N_KEYS-1:0] lp_done_q, lp_done_d;
  logic [N_KEYS-1:0] key_long_q, key_long_d;

  // ---------------------------------------------------------------------------
  // Stage 3: long-press hold counter, driven by the debounced level.
  // ---------------------------------------------------------------------------
  always_comb begin
    lp_done_d  = lp_done_q;
    key_long_d = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      lp_cnt_d[i] = lp_cnt_q[i];
      if (key_out_q[i]) begin
        lp_cnt_d[i]  = '0;
        lp_done_d[i] = 1'b0;
      end else if (lp_cnt_q[i] == LP_MAX) begin
        // Saturated: fire exactly once per hold.
        if (!lp_done_q[i]) begin
          key_long_d[i] = 1'b1;
          lp_done_d[i]  = 1'b1;
        end
      end else begin
        lp_cnt_d[i] = lp_cnt_q[i] + LP_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lp_done_q  <= '0;
      key_long_q <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        lp_cnt_q[i] <= '0;
      end
    end else begin
      lp_done_q  <= lp_done_d;
      key_long_q <= key_long_d;
      for (int i = 0; i < N_KEYS; i++) begin
        lp_cnt_q[i] <= lp_cnt_d[i];
      end
    end
  end

  assign key_long = key_long_q;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//   Directed bench for key_debounce with DB_CYCLES=4, LONG_CYCLES=16, N_KEYS=4.
//   The stimulus thread drives key_in/rst on the falling edge and, for every
//   level change it expects the DUT to accept, pushes the expected pulse event
//   (cycle, press, release, long, key_out) into a queue. A separate monitor
//   pops an event whenever any pulse output is high and compares all fields.
//   Cycle numbers count rising edges; an input driven while the count is t is
//   first sampled at edge t+1, so its accepted change appears at t+2+DB.
// -----------------------------------------------------------------------------
module tb_key_debounce;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int LC = 16;
  localparam int LAT = 2 + DB;

  logic         clk;
  logic         rst;
  logic [N-1:0] key_in;
  logic [N-1:0] key_out;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic [N-1:0] long_w;

  key_debounce #(
    .N_KEYS      (N),
    .DB_CYCLES   (DB),
    .LONG_CYCLES (LC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_out     (key_out),
    .key_press   (key_press),
    .key_release (key_release)
`ifdef KEY_LONG_PRESS_EN
    ,
    .key_long    (long_w)
`endif
  );

`ifndef KEY_LONG_PRESS_EN
  assign long_w = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           at;
    logic [N-1:0] p;
    logic [N-1:0] r;
    logic [N-1:0] l;
    logic [N-1:0] k;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_ev(input int at, input logic [N-1:0] p, input logic [N-1:0] r,
                         input logic [N-1:0] l, input logic [N-1:0] k);
    ev_t e;
    e.at = at; e.p = p; e.r = r; e.l = l; e.k = k;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every cycle with a pulse must match the next expected event.
  always @(negedge clk) begin
    if (key_press != '0 || key_release != '0 || long_w != '0) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: cycle=%0d press=%b release=%b long=%b", cyc,
                 key_press, key_release, long_w);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("event_cycle",   cyc,         e.at);
        check("event_press",   key_press,   e.p);
        check("event_release", key_release, e.r);
        check("event_long",    long_w,      e.l);
        check("event_key_out", key_out,     e.k);
      end
    end
  end

  int t;

  initial begin
    // 1. Reset with all keys held down.
    rst    = 1'b1;
    key_in = 4'b0000;
    tick(3);
    check("reset_key_out",     key_out,     4'b1111);
    check("reset_key_press",   key_press,   4'b0000);
    check("reset_key_release", key_release, 4'b0000);
    rst = 1'b0;
    t = cyc;
    push_ev(t + LAT, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    tick(LAT + 4);
    check("after_reset_press_all", key_out, 4'b0000);
    t = cyc;
    key_in = 4'b1111;
    push_ev(t + LAT, 4'b0000, 4'b1111, 4'b0000, 4'b1111);
    tick(LAT + 4);
    check("all_released", key_out, 4'b1111);

    // 2. Key 0 pressed and held.
    t = cyc;
    key_in[0] = 1'b0;
    push_ev(t + LAT, 4'b0001, 4'b0000, 4'b0000, 4'b1110);
    tick(LAT - 1);
    check("key0_before_accept", key_out, 4'b1111);
    tick(1);
    check("key0_pressed_level", key_out, 4'b1110);
    tick(1);
    check("key0_press_one_cycle", key_press, 4'b0000);
    tick(4);

    // 3. Key 1 glitch of DB-1 cycles: must be rejected.
    key_in[1] = 1'b0;
    tick(DB - 1);
    key_in[1] = 1'b1;
    tick(12);
    check("key1_glitch_rejected", key_out, 4'b1110);

    // 3b. Key 1 low for exactly DB cycles: accepted, then released.
    t = cyc;
    key_in[1] = 1'b0;
    push_ev(t + LAT, 4'b0010, 4'b0000, 4'b0000, 4'b1100);
    tick(DB);
    key_in[1] = 1'b1;
    push_ev(t + DB + LAT, 4'b0000, 4'b0010, 4'b0000, 4'b1110);
    tick(14);

    // 4. Keys 2 and 3 pressed and released together.
    t = cyc;
    key_in[3:2] = 2'b00;
    push_ev(t + LAT, 4'b1100, 4'b0000, 4'b0000, 4'b0010);
    tick(20);
    check("keys23_pressed_level", key_out, 4'b0010);
    t = cyc;
    key_in[3:2] = 2'b11;
    push_ev(t + LAT, 4'b0000, 4'b1100, 4'b0000, 4'b1110);
    tick(LAT + 4);

    // 5. Key 0 re-pressed, held 10 cycles, then a one-cycle reset.
    t = cyc;
    key_in[0] = 1'b1;
    push_ev(t + LAT, 4'b0000, 4'b0001, 4'b0000, 4'b1111);
    tick(LAT + 4);
    t = cyc;
    key_in[0] = 1'b0;
    push_ev(t + LAT, 4'b0001, 4'b0000, 4'b0000, 4'b1110);
    tick(LAT + 10);
    rst = 1'b1;
    tick(1);
    check("midreset_key_out",     key_out,     4'b1111);
    check("midreset_key_press",   key_press,   4'b0000);
    check("midreset_key_release", key_release, 4'b0000);
    rst = 1'b0;
    t = cyc;
    push_ev(t + LAT, 4'b0001, 4'b0000, 4'b0000, 4'b1110);
    tick(LAT + 4);
    t = cyc;
    key_in[0] = 1'b1;
    push_ev(t + LAT, 4'b0000, 4'b0001, 4'b0000, 4'b1111);
    tick(LAT + 4);

`ifdef KEY_LONG_PRESS_EN
    // 6. Key 3 held 40 cycles: one long pulse, then a normal release.
    t = cyc;
    key_in[3] = 1'b0;
    push_ev(t + LAT,      4'b1000, 4'b0000, 4'b0000, 4'b0111);
    push_ev(t + LAT + LC, 4'b0000, 4'b0000, 4'b1000, 4'b0111);
    tick(40);
    key_in[3] = 1'b1;
    push_ev(t + 40 + LAT, 4'b0000, 4'b1000, 4'b0000, 4'b1111);
    tick(LAT + 4);
`endif

    tick(4);
    check("final_key_out",        key_out,       4'b1111);
    check("pending_events_empty", exp_q.size(),  0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
